// File: rtl/end_banner_pkg.sv
// end_banner_pkg: shared state encoding and coordinate types for the end-of-game banner.
//   COORD_W  - width of unsigned raster coordinates
//   SCOORD_W - width of signed banner coordinates (holds negative Y during the slide)
package end_banner_pkg;
    localparam int COORD_W  = 11;
    localparam int SCOORD_W = 12;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic signed [SCOORD_W-1:0] scoord_t;
    typedef enum logic [1:0] {IDLE, SLIDE, HOLD} state_t;
endpackage

// File: rtl/frame_blink_timer.sv
// frame_blink_timer: counts frame ticks and toggles a visible/hidden phase every BLINK_FRAMES ticks.
//   clk, reset (async, active-high)
//   clear   - returns to count 0, visible phase
//   tick    - one-cycle frame pulse
//   visible - current blink phase (1 = drawn)
// Only built when END_BANNER_BLINK_EN is defined.
`ifdef END_BANNER_BLINK_EN
module frame_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic visible
);
    localparam int CW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            cnt     <= '0;
            visible <= 1'b1;
        end else if (tick) begin
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            visible <= (cnt == LAST) ? ~visible : visible;
        end
    end
endmodule
`endif

// File: rtl/end_banner_positioner.sv
// end_banner_positioner: slides the end-of-game banner down on gameOver and maps the raster pixel into banner-local coordinates.
//   clk, reset (async, active-high)
//   startOfFrame     - frame pulse; the only moment the banner moves
//   pixelX/pixelY    - current raster position
//   gameOver         - level; its rising edge starts the slide
//   restart          - pulse; returns the banner to IDLE above the screen
//   offsetX/offsetY  - banner-local pixel coordinates, 0 when outside (registered)
//   InsideRectangle  - pixel lies inside the visible banner (registered)
//   bannerSettled    - banner has reached its resting row
// Define END_BANNER_BLINK_EN to blink the banner while it rests.
module end_banner_positioner
    import end_banner_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int TOP_LEFT_X      = 304,
    parameter int START_Y         = -32,
    parameter int TARGET_Y        = 224,
    parameter int SPEED_Y         = 4
`ifdef END_BANNER_BLINK_EN
    ,
    parameter int BLINK_FRAMES    = 30
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        gameOver,
    input  logic        restart,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        bannerSettled
);
    localparam scoord_t X_L      = SCOORD_W'(TOP_LEFT_X);
    localparam scoord_t X_R      = SCOORD_W'(TOP_LEFT_X + OBJECT_WIDTH_X - 1);
    localparam scoord_t Y_START  = SCOORD_W'(START_Y);
    localparam scoord_t Y_TARGET = SCOORD_W'(TARGET_Y);
    localparam scoord_t Y_SPEED  = SCOORD_W'(SPEED_Y);
    localparam scoord_t Y_SPAN   = SCOORD_W'(OBJECT_HEIGHT_Y - 1);

    state_t  state;
    scoord_t top_y;
    logic    go_d;
    logic    visible;
    scoord_t px, py, next_y, y_bot;
    logic    go_rise, in_box;

    // Raster coordinates are never negative, so rows above the screen can never match.
    assign px      = {1'b0, pixelX};
    assign py      = {1'b0, pixelY};
    assign next_y  = top_y + Y_SPEED;
    assign y_bot   = top_y + Y_SPAN;
    assign go_rise = gameOver & ~go_d;
    assign in_box  = (state != IDLE) && visible && px >= X_L && px <= X_R && py >= top_y && py <= y_bot;

`ifdef END_BANNER_BLINK_EN
    // Held clear outside HOLD, so each HOLD entry starts visible at count 0.
    frame_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk     (clk),
        .reset   (reset),
        .clear   (restart || state != HOLD),
        .tick    (startOfFrame),
        .visible (visible)
    );
`else
    assign visible = 1'b1;
`endif

    // go_d keeps tracking gameOver through restart, so a still-high level cannot retrigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            top_y         <= Y_START;
            go_d          <= 1'b0;
            bannerSettled <= 1'b0;
        end else begin
            go_d <= gameOver;
            if (restart) begin
                state         <= IDLE;
                top_y         <= Y_START;
                bannerSettled <= 1'b0;
            end else if (state == IDLE && go_rise) begin
                state <= SLIDE;
            end else if (state == SLIDE && startOfFrame) begin
                if (next_y >= Y_TARGET) begin
                    top_y         <= Y_TARGET;
                    state         <= HOLD;
                    bannerSettled <= 1'b1;
                end else begin
                    top_y <= next_y;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= in_box;
            offsetX         <= in_box ? COORD_W'(px - X_L) : '0;
            offsetY         <= in_box ? COORD_W'(py - top_y) : '0;
        end
    end
endmodule
